sync_fifo_reader: RTL and testbench

Read-side engine for the team's synchronous FIFO. It pops words from the FIFO's registered read port and presents them on a valid/ready output stream. A 2-entry skid buffer with in-flight credit tracking absorbs the FIFO's 1-cycle read latency, so the stream sustains one word per cycle under continuous `m_ready`. It sits between a `sync_fifo` instance and any downstream consumer that can stall.

---
 rtl/sync_fifo_reader.sv | 101 ++++++++++
 tb/tb_sync_fifo_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_reader.sv
// Read-side engine for sync_fifo: a 2-entry skid buffer with in-flight credit tracking.
// Define SYNC_FIFO_READER_CNT_EN to build the output handshake counter on xfer_cnt.
module sync_fifo_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 m_ready,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             occ;
    logic             inflight;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;

    logic             pop;
    logic [2:0]       level;
    logic             credit_ok;

    assign pop        = m_valid & m_ready;
    assign level      = {1'b0, occ} + {2'b00, inflight};
    assign credit_ok  = (level < 3'd2);
    // A same-cycle pop frees a slot, so a read may still issue when all credits are spent.
    assign fifo_rd_en = !rst & en & !fifo_empty & (credit_ok | pop);

    assign m_valid    = (occ != EMPTY);
    assign m_data     = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= EMPTY;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            case ({inflight, pop})
                2'b10: begin
                    case (occ)
                        EMPTY: begin
                            head <= fifo_data;
                            occ  <= HALF;
                        end
                        HALF: begin
                            tail <= fifo_data;
                            occ  <= FULL;
                        end
                        default: begin
                        end
                    endcase
                end
                2'b01: begin
                    head <= tail;
                    occ  <= (occ == FULL) ? HALF : EMPTY;
                end
                // Shift happens before the write: the landing word fills the slot just vacated.
                2'b11: begin
                    if (occ == FULL) begin
                        head <= tail;
                        tail <= fifo_data;
                    end else begin
                        head <= fifo_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SYNC_FIFO_READER_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Scoreboard bench for sync_fifo_reader with a behavioural registered-read FIFO in front of it.
// Expected words are queued by the stimulus; a negedge monitor checks every handshake.
module tb_sync_fifo_reader;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             fifo_rst = 1'b0;
    logic             en       = 1'b1;
    logic             m_ready  = 1'b0;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             fifo_rd_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [CW-1:0]    xfer_cnt;

    logic [WIDTH-1:0] fifo_mem [256];
    int               wr_ptr = 0;
    int               rd_ptr = 0;

    logic [WIDTH-1:0] exp_mem [256];
    int               exp_wr = 0;
    int               exp_rd = 0;

    int               vectors     = 0;
    int               miscompares = 0;

    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    sync_fifo_reader #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .xfer_cnt   (xfer_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: data_out is registered, so a pop at edge N shows its word after edge N.
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= fifo_mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] word, input bit expect_out);
        fifo_mem[wr_ptr % 256] = word;
        wr_ptr++;
        if (expect_out) begin
            exp_mem[exp_wr % 256] = word;
            exp_wr++;
        end
    endtask

    function automatic logic [31:0] expCnt(input int n);
`ifdef SYNC_FIFO_READER_CNT_EN
        return 32'(n % (1 << CW));
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic waitDrain(input string name, input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (exp_rd == exp_wr && !m_valid && fifo_empty) done = 1'b1;
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    // Monitor: every handshake must match the next queued word; stalls must hold the output.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (exp_rd == exp_wr) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_word: got 0x%02h, expected no word at %0t", m_data, $time);
            end else begin
                checkOutput("stream_data", 32'(m_data), 32'(exp_mem[exp_rd % 256]));
                exp_rd++;
            end
        end
        if (prev_stall) begin
            checkOutput("stall_valid", 32'(m_valid), 32'd1);
            checkOutput("stall_data", 32'(m_data), 32'(prev_data));
        end
        if (!rst) checkOutput("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
        prev_stall = m_valid & !m_ready & !rst;
        prev_data  = m_data;
    end

    initial begin
        int base;
        int ebase;
        int lat;
        bit found;

        // Reset held two cycles with a word sitting in the FIFO.
        applyStimulus(8'h55, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rd_en_c1", 32'(fifo_rd_en), 32'd0);
        fifo_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rd_en_c2", 32'(fifo_rd_en), 32'd0);
        checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset_m_data", 32'(m_data), 32'd0);
        checkOutput("reset_xfer_cnt", 32'(xfer_cnt), 32'd0);
        rst      = 1'b0;
        fifo_rst = 1'b0;

        // Streaming 0x01..0x08 at full rate.
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) applyStimulus(WIDTH'(i), 1'b1);
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (m_valid) found = 1'b1;
        end
        checkOutput("stream_latency", 32'(lat), 32'd3);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checkOutput("stream_no_gap", 32'(m_valid), 32'd1);
        end
        @(negedge clk);
        checkOutput("stream_end_valid", 32'(m_valid), 32'd0);
        checkOutput("stream_xfer_cnt", 32'(xfer_cnt), expCnt(8));

        // Backpressure: 0x10..0x15 with the consumer stalled for six cycles.
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        base = rd_ptr;
        for (int i = 0; i < 6; i++) applyStimulus(WIDTH'(8'h10 + i), 1'b1);
        repeat (6) @(negedge clk);
        checkOutput("stall_reads", 32'(rd_ptr - base), 32'd2);
        checkOutput("stall_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("stall_head_valid", 32'(m_valid), 32'd1);
        checkOutput("stall_head_data", 32'(m_data), 32'h10);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("release_no_gap", 32'(m_valid), 32'd1);
        end
        @(negedge clk);
        checkOutput("release_end_valid", 32'(m_valid), 32'd0);
        checkOutput("release_xfer_cnt", 32'(xfer_cnt), expCnt(14));

        // Enable dropped right after the read of 0x03 is issued.
        @(posedge clk);
        #1;
        base  = rd_ptr;
        ebase = exp_wr;
        for (int i = 1; i <= 6; i++) applyStimulus(WIDTH'(i), 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (fifo_rd_en && rd_ptr == base + 2) found = 1'b1;
        end
        checkOutput("en_find_read3", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("en_low_reads", 32'(rd_ptr - base), 32'd3);
        checkOutput("en_low_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("en_low_delivered", 32'(exp_rd - ebase), 32'd3);
        checkOutput("en_low_valid", 32'(m_valid), 32'd0);
        @(posedge clk);
        #1;
        en = 1'b1;
        waitDrain("en_resume_drain", 30);
        checkOutput("en_xfer_cnt", 32'(xfer_cnt), expCnt(20));

        // Reset with one word buffered and one in flight; those words must vanish.
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        base = rd_ptr;
        for (int i = 0; i < 3; i++) applyStimulus(WIDTH'(8'h30 + i), 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("midrst_reads", 32'(rd_ptr - base), 32'd2);
        checkOutput("midrst_pre_valid", 32'(m_valid), 32'd1);
        rst      = 1'b1;
        fifo_rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        fifo_rst = 1'b0;
        checkOutput("midrst_valid", 32'(m_valid), 32'd0);
        checkOutput("midrst_data", 32'(m_data), 32'd0);
        checkOutput("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        m_ready = 1'b1;
        applyStimulus(8'hA0, 1'b1);
        waitDrain("midrst_drain", 20);
        checkOutput("midrst_after_cnt", 32'(xfer_cnt), expCnt(1));

        // Counter wrap: 17 transfers on a 4-bit counter.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("wrap_start_cnt", 32'(xfer_cnt), 32'd0);
        for (int i = 0; i < 17; i++) applyStimulus(WIDTH'(8'h40 + i), 1'b1);
        waitDrain("wrap_drain", 60);
        checkOutput("wrap_xfer_cnt", 32'(xfer_cnt), expCnt(17));
        checkOutput("all_words_seen", 32'(exp_rd), 32'(exp_wr));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
